conv_window_gen: RTL and testbench
==================================

// Module: conv_window_gen
// PURPOSE
//  Parametrised successor to the fixed 3x3 single-channel line-buffer front end of the convolution controller.
//  Accepts a raster pixel stream (all channels of one pixel per beat) and buffers KERNEL_SIZE-1 rows in RAM.
//  Emits one flat KxK window per channel with runtime stride and valid/ready backpressure.
//  Sits between the AXI4-S slave input and the ma_int_16 multiplier arrays; window layout matches MULTIPLIER_INPUT.
// PARAMETERS
//  KERNEL_SIZE  3     window edge K (>=2)
//  CHANNELS     1     channels per pixel beat
//  DATA_WIDTH   32    bits per channel sample
//  MAX_WIDTH    1024  max line length; line-buffer RAM depth
//  DIM_BITS     16    width of cfg_width/cfg_height and internal row/col counters
// PORTS
//  axi_clk          in   1                           clock
//  axi_reset        in   1                           synchronous active-high reset
//  cfg_enable       in   1                           arm block; sampled in IDLE
//  cfg_width        in   DIM_BITS                    pixels per line
//  cfg_height       in   DIM_BITS                    lines per frame
//  cfg_stride       in   2                           window stride, 1..3 (0 treated as 1)
//  s_axis_valid     in   1                           input beat valid
//  s_axis_data      in   CHANNELS*DATA_WIDTH         channel n at [n*DATA_WIDTH+:DATA_WIDTH]
//  s_axis_last      in   1                           last pixel of frame
//  s_axis_ready     out  1                           input accepted when valid&ready
//  m_win_valid      out  1                           window valid
//  m_win_data       out  CHANNELS*K*K*DATA_WIDTH     window; see layout
//  m_win_last       out  1                           final window of frame
//  m_win_ready      in   1                           downstream accepts window
//  frame_done       out  1                           1-cycle pulse at end of frame
//  err_cfg          out  1                           sticky: bad config rejected
//  err_short_frame  out  1                           sticky: s_axis_last before expected pixel count
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0, including s_axis_ready, m_win_valid, errs and m_win_data; row/col/stride counters 0.
//   Line-buffer RAM contents are not cleared; they are never read before being rewritten.
//  States:
//   IDLE->RUN: cfg_enable=1 with K<=cfg_width<=MAX_WIDTH and cfg_height>=K.
//    Latch width, height and stride on that edge; clear both errs.
//    Bad config: set err_cfg and stay in IDLE.
//   RUN->FLUSH: accepting pixel (width*height-1).
//   FLUSH->IDLE: output register empty; pulse frame_done on the same cycle.
//  s_axis_ready = (state==RUN) & (!m_win_valid | m_win_ready).
//  Accepted beat:
//   - Shift the column of K samples into the KxK window regs: K-1 from line RAMs at col, plus the new pixel.
//   - Write the new pixel into line RAM ring at col.
//   - col++; at width-1, col wraps to 0 and row++.
//  Window emit condition on the beat at (row,col):
//   - row>=K-1 and col>=K-1, and
//   - (row-(K-1)) % stride == 0 and (col-(K-1)) % stride == 0.
//   - Implement the stride checks with phase counters; no divider.
//  Latency: m_win_valid asserts the cycle after the completing beat.
//   Data is held stable while valid&!ready; it clears on the handshake unless a new window loads on the same cycle.
//  Layout: m_win_data[((n*K*K)+r*K+c)*DATA_WIDTH+:DATA_WIDTH].
//   n = channel; r=0 is the oldest row; c=0 is the leftmost column.
//  m_win_last=1 with the window whose completing beat is the final pixel of the frame.
//   If stride skips that position, m_win_last rides the last emitted window instead.
//  s_axis_last with fewer pixels than width*height:
//   - set err_short_frame; drop any pending window; go to IDLE.
//   - no m_win_last and no frame_done for that frame.
//  s_axis_last absent on the final pixel: ignored; the frame still completes normally.
//  Back-to-back frames: IDLE re-arms on the next cycle if cfg_enable is still high.
//  Reset mid-frame: immediate return to IDLE; the next frame is unaffected.
// TESTING
//  T1 8x8, K=3, stride 1, pixel=col+8*row:
//   - 36 windows.
//   - First window {0,1,2,8,9,10,16,17,18}.
//   - Last window center 54, with m_win_last=1 and frame_done one cycle after its handshake.
//  T2 same frame, stride 2: 9 windows, centers 9,11,13,25,...,45; m_win_last on center 45.
//  T3 T1 with m_win_ready held low 5 cycles at window 4:
//   - s_axis_ready low within 1 cycle.
//   - m_win_data stable throughout; all 36 windows correct, none lost or duplicated.
//  T4 CHANNELS=2, ch1=ch0+100:
//   - Channel 1 slice = channel 0 slice + 100 for every window.
//   - Channel 0 slice matches T1.
//  T5 s_axis_last on pixel 20 of 8x8: err_short_frame=1, state IDLE, no frame_done.
//   Next clean frame reproduces T1.
//  T6 cfg_width=2 (K=3): err_cfg=1 and s_axis_ready stays 0.
//   axi_reset pulsed mid-T1: all outputs 0; the rerun frame is correct.

Source files
------------

// File: rtl/conv_window_gen.sv
// Sliding KxK window generator for a raster pixel stream.
// Buffers KERNEL_SIZE-1 lines in RAM and emits one flat KxK window per channel,
// with runtime stride and valid/ready backpressure on both sides.
module conv_window_gen #(
  parameter int KERNEL_SIZE = 3,
  parameter int CHANNELS    = 1,
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_WIDTH   = 1024,
  parameter int DIM_BITS    = 16
) (
  input  logic                                            axi_clk,
  input  logic                                            axi_reset,
  input  logic                                            cfg_enable,
  input  logic [DIM_BITS-1:0]                             cfg_width,
  input  logic [DIM_BITS-1:0]                             cfg_height,
  input  logic [1:0]                                      cfg_stride,
  input  logic                                            s_axis_valid,
  input  logic [CHANNELS*DATA_WIDTH-1:0]                  s_axis_data,
  input  logic                                            s_axis_last,
  output logic                                            s_axis_ready,
  output logic                                            m_win_valid,
  output logic [CHANNELS*KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] m_win_data,
  output logic                                            m_win_last,
  input  logic                                            m_win_ready,
  output logic                                            frame_done,
  output logic                                            err_cfg,
  output logic                                            err_short_frame
);

  localparam int K  = KERNEL_SIZE;
  localparam int PW = CHANNELS * DATA_WIDTH;
  localparam int WW = CHANNELS * K * K * DATA_WIDTH;
  localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam logic [DIM_BITS-1:0] K_D    = DIM_BITS'(K);
  localparam logic [DIM_BITS-1:0] KM1_D  = DIM_BITS'(K - 1);
  localparam logic [DIM_BITS-1:0] MAXW_D = DIM_BITS'(MAX_WIDTH);
  localparam logic [DIM_BITS-1:0] ONE_D  = DIM_BITS'(1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t state;

  logic [DIM_BITS-1:0] width_q, height_q, last_col_q, last_row_q;
  logic [DIM_BITS-1:0] row, col;
  logic [1:0]          stride_q, row_ph, col_ph;

  // Line RAMs: index 0 holds the oldest buffered row.
  logic [PW-1:0] line_ram [K-1][MAX_WIDTH];
  logic [PW-1:0] win_p0   [K][K];
  logic [PW-1:0] col_rd   [K];
  logic [PW-1:0] win_nxt  [K][K];
  logic [WW-1:0] win_flat;
  logic [AW-1:0] addr;

  logic accept, drain, cfg_ok, final_pix, emit, is_last;

  assign addr         = col[AW-1:0];
  assign s_axis_ready = (state == RUN) && (!m_win_valid || m_win_ready);
  assign accept       = s_axis_valid && s_axis_ready;
  assign drain        = m_win_valid && m_win_ready;
  assign cfg_ok       = (cfg_width >= K_D) && (cfg_width <= MAXW_D) && (cfg_height >= K_D);
  assign final_pix    = (row == last_row_q) && (col == last_col_q);
  assign emit         = (row >= KM1_D) && (col >= KM1_D) && (row_ph == 2'd0) && (col_ph == 2'd0);
  // No later window exists once neither the column nor the row can advance by a stride.
  assign is_last      = ((col + DIM_BITS'(stride_q)) >= width_q) &&
                        ((row + DIM_BITS'(stride_q)) >= height_q);

  // Column entering the window: buffered rows at this column plus the new pixel.
  always_comb begin
    for (int r = 0; r < K - 1; r++) col_rd[r] = line_ram[r][addr];
    col_rd[K-1] = s_axis_data;
  end

  // Window after shifting left by one column and appending the incoming column.
  always_comb begin
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) win_nxt[r][c] = win_p0[r][c+1];
      win_nxt[r][K-1] = col_rd[r];
    end
  end

  // Flatten to channel-major, row-major, column-minor layout for the multipliers.
  always_comb begin
    win_flat = '0;
    for (int n = 0; n < CHANNELS; n++)
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          win_flat[((n*K*K) + r*K + c)*DATA_WIDTH +: DATA_WIDTH] =
            win_nxt[r][c][n*DATA_WIDTH +: DATA_WIDTH];
  end

  // Datapath: shift line buffers up one row at this column and update the window.
  always_ff @(posedge axi_clk) begin
    if (accept) begin
      for (int j = 0; j < K - 1; j++) line_ram[j][addr] <= col_rd[j+1];
      win_p0 <= win_nxt;
    end
  end

  // Control FSM, raster counters with stride phases, output register and status.
  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      state           <= IDLE;
      width_q         <= '0;
      height_q        <= '0;
      last_col_q      <= '0;
      last_row_q      <= '0;
      stride_q        <= '0;
      row             <= '0;
      col             <= '0;
      row_ph          <= '0;
      col_ph          <= '0;
      m_win_valid     <= 1'b0;
      m_win_data      <= '0;
      m_win_last      <= 1'b0;
      frame_done      <= 1'b0;
      err_cfg         <= 1'b0;
      err_short_frame <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_enable) begin
            if (cfg_ok) begin
              state           <= RUN;
              width_q         <= cfg_width;
              height_q        <= cfg_height;
              last_col_q      <= cfg_width - ONE_D;
              last_row_q      <= cfg_height - ONE_D;
              stride_q        <= (cfg_stride == 2'd0) ? 2'd1 : cfg_stride;
              row             <= '0;
              col             <= '0;
              row_ph          <= '0;
              col_ph          <= '0;
              err_cfg         <= 1'b0;
              err_short_frame <= 1'b0;
            end else begin
              err_cfg <= 1'b1;
            end
          end
        end
        RUN: begin
          if (drain) begin
            m_win_valid <= 1'b0;
            m_win_data  <= '0;
            m_win_last  <= 1'b0;
          end
          if (accept) begin
            if (s_axis_last && !final_pix) begin
              err_short_frame <= 1'b1;
              m_win_valid     <= 1'b0;
              m_win_data      <= '0;
              m_win_last      <= 1'b0;
              state           <= IDLE;
            end else begin
              if (emit) begin
                m_win_valid <= 1'b1;
                m_win_data  <= win_flat;
                m_win_last  <= is_last;
              end
              if (col == last_col_q) begin
                col    <= '0;
                col_ph <= '0;
                row    <= row + ONE_D;
                if (row >= KM1_D) row_ph <= (row_ph == stride_q - 2'd1) ? 2'd0 : row_ph + 2'd1;
              end else begin
                col <= col + ONE_D;
                if (col >= KM1_D) col_ph <= (col_ph == stride_q - 2'd1) ? 2'd0 : col_ph + 2'd1;
              end
              if (final_pix) state <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (!m_win_valid || m_win_ready) begin
            m_win_valid <= 1'b0;
            m_win_data  <= '0;
            m_win_last  <= 1'b0;
            frame_done  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: 8x8 frames with K=3, two channels (ch1 = ch0 + 100).
module tb_conv_window_gen;

  localparam int K    = 3;
  localparam int CH   = 2;
  localparam int DW   = 16;
  localparam int MAXW = 16;
  localparam int DB   = 16;
  localparam int PW   = CH * DW;
  localparam int WW   = CH * K * K * DW;

  logic          axi_clk = 1'b0;
  logic          axi_reset = 1'b1;
  logic          cfg_enable = 1'b0;
  logic [DB-1:0] cfg_width = '0;
  logic [DB-1:0] cfg_height = '0;
  logic [1:0]    cfg_stride = '0;
  logic          s_axis_valid = 1'b0;
  logic [PW-1:0] s_axis_data = '0;
  logic          s_axis_last = 1'b0;
  logic          s_axis_ready;
  logic          m_win_valid;
  logic [WW-1:0] m_win_data;
  logic          m_win_last;
  logic          m_win_ready = 1'b1;
  logic          frame_done;
  logic          err_cfg;
  logic          err_short_frame;

  int n_checks = 0;
  int n_errors = 0;

  conv_window_gen #(
    .KERNEL_SIZE(K), .CHANNELS(CH), .DATA_WIDTH(DW), .MAX_WIDTH(MAXW), .DIM_BITS(DB)
  ) dut (
    .axi_clk(axi_clk), .axi_reset(axi_reset), .cfg_enable(cfg_enable),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_stride(cfg_stride),
    .s_axis_valid(s_axis_valid), .s_axis_data(s_axis_data), .s_axis_last(s_axis_last),
    .s_axis_ready(s_axis_ready), .m_win_valid(m_win_valid), .m_win_data(m_win_data),
    .m_win_last(m_win_last), .m_win_ready(m_win_ready), .frame_done(frame_done),
    .err_cfg(err_cfg), .err_short_frame(err_short_frame)
  );

  always #5 axi_clk = ~axi_clk;

  task automatic check(input string tag, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] pix(input int w, input int r, input int c);
    logic [PW-1:0] v;
    v[0 +: DW]  = DW'(c + w*r);
    v[DW +: DW] = DW'(c + w*r + 100);
    return v;
  endfunction

  function automatic logic [WW-1:0] win_at(input int w, input int row, input int col);
    logic [WW-1:0] v;
    v = '0;
    for (int n = 0; n < CH; n++)
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          v[((n*K*K) + r*K + c)*DW +: DW] = DW'((col - (K-1) + c) + w*(row - (K-1) + r) + 100*n);
    return v;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_s_ready"},  s_axis_ready, 0);
    check({tag, "_m_valid"},  m_win_valid, 0);
    check({tag, "_m_data"},   m_win_data, 0);
    check({tag, "_m_last"},   m_win_last, 0);
    check({tag, "_done"},     frame_done, 0);
    check({tag, "_err_cfg"},  err_cfg, 0);
    check({tag, "_err_short"}, err_short_frame, 0);
  endtask

  task automatic run_frame(input int w, input int h, input int st, input int short_at,
                           input int abort_at, input bit stall);
    logic [WW-1:0] exp_q[$];
    logic [WW-1:0] held;
    int centers2[9] = '{9, 11, 13, 25, 27, 29, 41, 43, 45};
    int first_vals[9] = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
    int npix, p, nwin, cyc, last_hs, stall_cnt, tail, ste;
    bit done, fd_seen;
    npix = w*h; p = 0; nwin = 0; cyc = 0; last_hs = -10; stall_cnt = 0; tail = 0;
    done = 0; fd_seen = 0; held = '0;
    ste = (st == 0) ? 1 : st;
    for (int r = K-1; r < h; r += ste)
      for (int c = K-1; c < w; c += ste)
        exp_q.push_back(win_at(w, r, c));

    @(negedge axi_clk);
    cfg_width = DB'(w); cfg_height = DB'(h); cfg_stride = 2'(st); cfg_enable = 1'b1;
    @(negedge axi_clk);
    cfg_enable = 1'b0;
    check("arm_err_cfg", err_cfg, 0);
    check("arm_err_short", err_short_frame, 0);

    while (!done) begin
      @(negedge axi_clk);
      cyc++;
      if (frame_done) begin
        fd_seen = 1;
        if (short_at < 0) begin
          if (st == 1) check("done_timing", cyc, last_hs + 1);
          done = 1;
        end
      end
      if (stall && nwin == 4 && m_win_valid && stall_cnt < 5) begin
        m_win_ready = 1'b0;
        if (stall_cnt == 0) held = m_win_data;
        else check("stall_hold", m_win_data, held);
        stall_cnt++;
      end else begin
        m_win_ready = 1'b1;
      end
      if (!done && p < npix && (short_at < 0 || p <= short_at) && (abort_at < 0 || p < abort_at)) begin
        s_axis_valid = 1'b1;
        s_axis_data  = pix(w, p / w, p % w);
        s_axis_last  = (p == npix - 1) || (p == short_at);
      end else begin
        s_axis_valid = 1'b0;
        s_axis_last  = 1'b0;
      end
      #1;
      if (!m_win_ready) check("stall_s_ready", s_axis_ready, 0);
      if (m_win_valid && m_win_ready) begin
        if (nwin < exp_q.size()) begin
          check("win_data", m_win_data, exp_q[nwin]);
          check("win_last", m_win_last, (nwin == exp_q.size() - 1));
        end else begin
          check("extra_win", nwin, exp_q.size());
        end
        check("ch1_offset", m_win_data[(K*K + 4)*DW +: DW], m_win_data[4*DW +: DW] + DW'(100));
        if (st == 2 && nwin < 9) check("center_s2", m_win_data[4*DW +: DW], centers2[nwin]);
        if (st == 1 && nwin == 0)
          for (int i = 0; i < K*K; i++) check("first_win", m_win_data[i*DW +: DW], first_vals[i]);
        if (st == 1 && m_win_last) check("last_center", m_win_data[4*DW +: DW], 54);
        nwin++;
        last_hs = cyc;
      end
      if (s_axis_valid && s_axis_ready) p++;
      if (abort_at >= 0 && p >= abort_at) done = 1;
      if (short_at >= 0 && p > short_at) begin
        tail++;
        if (tail > 8) done = 1;
      end
      if (cyc > 4000) begin
        check("timeout", cyc, 0);
        done = 1;
      end
    end
    s_axis_valid = 1'b0;
    s_axis_last  = 1'b0;
    m_win_ready  = 1'b1;
    if (abort_at < 0 && short_at < 0) begin
      check("win_count", nwin, exp_q.size());
      check("done_seen", fd_seen, 1);
    end
    if (stall) check("stall_cycles", stall_cnt, 5);
    if (short_at >= 0) begin
      check("short_err", err_short_frame, 1);
      check("short_idle_ready", s_axis_ready, 0);
      check("short_no_done", fd_seen, 0);
      check("short_no_valid", m_win_valid, 0);
    end
  endtask

  initial begin
    repeat (3) @(negedge axi_clk);
    check_all_zero("reset");
    axi_reset = 1'b0;

    // Stride 1, stride 2, then stride 1 with a 5-cycle downstream stall.
    run_frame(8, 8, 1, -1, -1, 1'b0);
    run_frame(8, 8, 2, -1, -1, 1'b0);
    run_frame(8, 8, 1, -1, -1, 1'b1);

    // Early s_axis_last on pixel 20, then a clean frame.
    run_frame(8, 8, 1, 20, -1, 1'b0);
    run_frame(8, 8, 1, -1, -1, 1'b0);

    // Width below the kernel size is rejected and the input stays closed.
    @(negedge axi_clk);
    cfg_width = DB'(2); cfg_height = DB'(8); cfg_stride = 2'd1; cfg_enable = 1'b1;
    s_axis_valid = 1'b1;
    @(negedge axi_clk);
    cfg_enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("badcfg_err", err_cfg, 1);
      check("badcfg_ready", s_axis_ready, 0);
      @(negedge axi_clk);
    end
    s_axis_valid = 1'b0;

    // Reset in the middle of a frame, then a full frame.
    run_frame(8, 8, 1, -1, 30, 1'b0);
    axi_reset = 1'b1;
    @(negedge axi_clk);
    check_all_zero("midreset");
    axi_reset = 1'b0;
    run_frame(8, 8, 1, -1, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
